// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Bit-counter width for a given operand width (WIDTH >= 2 keeps this >= 1).
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/fullsub_cell.sv
// Combinational full-subtractor cell: d = a - b - bin, bo = borrow out.
module fullsub_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bo
);

   assign d  = a ^ b ^ bin;
   assign bo = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB-first through one fullsub_cell with a registered borrow.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int unsigned      CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_sr, b_sr, d_sr;
   logic               brw;
   logic [CNT_W-1:0]   cnt;
   logic               cell_d, cell_bo;
   logic               last;

   fullsub_cell u_cell (
      .a   (a_sr[0]),
      .b   (b_sr[0]),
      .bin (brw),
      .d   (cell_d),
      .bo  (cell_bo)
   );

   assign last = (cnt == CNT_LAST);
   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_SHIFT;
         S_SHIFT: if (last)  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_sr    <= '0;
         b_sr    <= '0;
         d_sr    <= '0;
         brw     <= 1'b0;
         cnt     <= '0;
         diff    <= '0;
         bout    <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_sr <= a;
                  b_sr <= b;
                  brw  <= 1'b0;
                  cnt  <= '0;
               end
            end
            S_SHIFT: begin
               a_sr <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr <= {1'b0, b_sr[WIDTH-1:1]};
               d_sr <= {cell_d, d_sr[WIDTH-1:1]};
               brw  <= cell_bo;
               cnt  <= cnt + 1'b1;
               // Outputs only change on the final bit so the consumer sees a stable result.
               if (last) begin
                  diff <= {cell_d, d_sr[WIDTH-1:1]};
                  bout <= cell_bo;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
